conv_window_scheduler: RTL

Sequencing controller for the 14×14 IFM / 3×3 weight convolution datapath. It counts an incoming pixel stream and drives the weight-buffer and IFM-buffer write strobes and addresses. It tells the MAC array when a complete 3×3 window sits in the buffers and where that window starts. It also generates the aligned `out_valid`, the output count and the end-of-frame handshake, suppressing the row-wrap positions that yield no valid output.

---
 rtl/conv_window_scheduler_if.sv | 40 ++++
 rtl/conv_window_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler_if.sv
// conv_window_scheduler_if
// Bundles the pixel-stream input and every strobe, address and status output
// of the convolution window scheduler.
//   in_valid   : one pixel (and one weight on the first K*K beats) this cycle
//   wgt_we/addr: weight buffer write strobe and index
//   ifm_we/addr: IFM buffer write strobe and linear pixel index
//   mac_en     : complete 3x3 window present, win_base gives its top-left pixel
//   out_valid  : mac_en delayed by the MAC latency
//   out_cnt    : outputs produced so far in this frame
//   frame_done : single-cycle pulse on the last output of the frame
//   busy       : scheduler is not idle
//   ovf_err    : sticky, a beat arrived while the scheduler was draining
// The master modport is the stream source side; the slave modport is the
// scheduler itself.
interface conv_window_scheduler_if;
  logic       in_valid;
  logic       wgt_we;
  logic [3:0] wgt_addr;
  logic       ifm_we;
  logic [7:0] ifm_addr;
  logic       mac_en;
  logic [7:0] win_base;
  logic       out_valid;
  logic [7:0] out_cnt;
  logic       frame_done;
  logic       busy;
  logic       ovf_err;

  modport master (
    output in_valid,
    input  wgt_we, wgt_addr, ifm_we, ifm_addr, mac_en, win_base,
    input  out_valid, out_cnt, frame_done, busy, ovf_err
  );

  modport slave (
    input  in_valid,
    output wgt_we, wgt_addr, ifm_we, ifm_addr, mac_en, win_base,
    output out_valid, out_cnt, frame_done, busy, ovf_err
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler
// Sequencing controller for the IMG_W x IMG_H IFM / KxK weight convolution
// datapath. Counts the incoming pixel stream, writes weights and pixels into
// their buffers, flags each complete window to the MAC array and produces the
// aligned output valid, output count and end-of-frame pulse.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : conv_window_scheduler_if.slave, stream input plus all outputs
// Every output is a register and resets to 0.
module conv_window_scheduler #(
  parameter int IMG_W   = 14,
  parameter int IMG_H   = 14,
  parameter int K       = 3,
  parameter int MAC_LAT = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  conv_window_scheduler_if.slave bus
);

  localparam logic [7:0] LOAD_END   = 8'((K - 1) * IMG_W + K - 1);
  localparam logic [7:0] LAST_PIX   = 8'(IMG_W * IMG_H - 1);
  localparam logic [7:0] WIN_OFFSET = 8'((K - 1) * IMG_W + (K - 1));
  localparam logic [7:0] NUM_WGT    = 8'(K * K);
  localparam logic [7:0] OUT_TOTAL  = 8'((IMG_W - K + 1) * (IMG_H - K + 1));
  localparam logic [3:0] COL_LAST   = 4'(IMG_W - 1);
  localparam logic [3:0] EDGE       = 4'(K - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t r_state;
  logic   r_busy;
  logic   r_ovfErr;

  logic [7:0] r_n;
  logic [3:0] r_row;
  logic [3:0] r_col;

  logic       r_wgtWe;
  logic [3:0] r_wgtAddr;
  logic       r_ifmWe;
  logic [7:0] r_ifmAddr;

  logic       r_winPend;
  logic [7:0] r_winBasePend;
  logic       r_macEn;
  logic [7:0] r_winBase;

  logic [MAC_LAT-1:0] r_tap;
  logic [7:0]         r_outCnt;
  logic               r_frameDone;

  logic               w_accept;
  logic               w_winValid;
  logic               w_lastPix;
  logic               w_isWgt;
  logic [MAC_LAT-1:0] w_tapIn;
  logic               w_outValidNext;

  // A beat is taken in every state except DRAIN; in IDLE it becomes pixel 0
  // because the counters are already cleared there.
  assign w_accept   = bus.in_valid && (r_state != DRAIN);
  assign w_winValid = (r_row >= EDGE) && (r_col >= EDGE);
  assign w_lastPix  = (r_n == LAST_PIX);
  assign w_isWgt    = (r_n < NUM_WGT);

  // Frame-level state machine. busy and the sticky overflow flag are updated
  // alongside the state so they line up with it. DRAIN leaves at the edge that
  // closes the frame_done cycle, so a new frame can begin in the very next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_ovfErr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (w_accept && (r_n == LOAD_END)) begin
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (w_accept && w_lastPix) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.in_valid) begin
            r_ovfErr <= 1'b1;
          end
          if (r_frameDone) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pixel position. Row and column are kept as their own counters next to the
  // linear index so the window test needs no divider. All three clear when the
  // last pixel is taken, leaving them ready for the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n   <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (w_lastPix) begin
        r_n   <= '0;
        r_row <= '0;
        r_col <= '0;
      end else begin
        r_n <= r_n + 8'd1;
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + 4'd1;
        end else begin
          r_col <= r_col + 4'd1;
        end
      end
    end
  end

  // Buffer write strobes, one cycle after the beat. Addresses hold their last
  // value while the strobe is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wgtWe   <= 1'b0;
      r_wgtAddr <= '0;
      r_ifmWe   <= 1'b0;
      r_ifmAddr <= '0;
    end else begin
      r_wgtWe <= w_accept && w_isWgt;
      r_ifmWe <= w_accept;
      if (w_accept && w_isWgt) begin
        r_wgtAddr <= r_n[3:0];
      end
      if (w_accept) begin
        r_ifmAddr <= r_n;
      end
    end
  end

  // Window detection runs through two stages so mac_en shows up one cycle
  // after the IFM write of the window's last pixel has landed. Pixels in the
  // first K-1 columns of a row complete no window (row-wrap positions).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_winPend     <= 1'b0;
      r_winBasePend <= '0;
      r_macEn       <= 1'b0;
      r_winBase     <= '0;
    end else begin
      r_winPend <= w_accept && w_winValid;
      if (w_accept && w_winValid) begin
        r_winBasePend <= r_n - WIN_OFFSET;
      end
      r_macEn <= r_winPend;
      if (r_winPend) begin
        r_winBase <= r_winBasePend;
      end
    end
  end

  // Delay line input: tap 0 takes mac_en, each later tap takes the previous
  // one. The last tap's input is the out_valid of the next cycle, which lets
  // the output counter move in step with out_valid.
  always_comb begin
    w_tapIn    = '0;
    w_tapIn[0] = r_macEn;
    for (int i = 1; i < MAC_LAT; i++) begin
      w_tapIn[i] = r_tap[i-1];
    end
  end

  assign w_outValidNext = w_tapIn[MAC_LAT-1];

  // Output accounting. The count includes the output shown in the same cycle,
  // so frame_done rises exactly when it reaches the total; the count clears in
  // the cycle after frame_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tap       <= '0;
      r_outCnt    <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_tap       <= w_tapIn;
      r_frameDone <= w_outValidNext && (r_outCnt == OUT_TOTAL - 8'd1);
      if (w_outValidNext) begin
        if (r_outCnt != OUT_TOTAL) begin
          r_outCnt <= r_outCnt + 8'd1;
        end
      end else if (r_frameDone) begin
        r_outCnt <= '0;
      end
    end
  end

  assign bus.wgt_we     = r_wgtWe;
  assign bus.wgt_addr   = r_wgtAddr;
  assign bus.ifm_we     = r_ifmWe;
  assign bus.ifm_addr   = r_ifmAddr;
  assign bus.mac_en     = r_macEn;
  assign bus.win_base   = r_winBase;
  assign bus.out_valid  = r_tap[MAC_LAT-1];
  assign bus.out_cnt    = r_outCnt;
  assign bus.frame_done = r_frameDone;
  assign bus.busy       = r_busy;
  assign bus.ovf_err    = r_ovfErr;

endmodule
